md_unit: RTL and testbench

- Multi-cycle multiply/divide unit with HI/LO registers, instantiated inside the EX stage.
- It drives the `busy` signal that the hazard unit uses to stall the pipeline.
- It accepts one operation per start pulse from EX and holds HI/LO for mfhi/mflo reads in EX.
- mthi/mtlo writes complete in a single cycle.

---
 rtl/md_unit.sv | 147 ++++++++++++++
 tb/tb_md_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the EX stage.
// The result is computed when the operation is accepted and written to HI/LO when the busy window ends.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  // state   | meaning
  // IDLE    | no operation in flight; accepts start (mult/div/mthi/mtlo)
  // RUN     | mult/div in flight; counter runs down, HI/LO written at terminal count
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] phi_q, phi_d;
  logic [31:0] plo_q, plo_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        div_zero;
  logic [31:0] divisor;
  logic [31:0] mag_a, mag_b;
  logic [31:0] q_mag, r_mag;
  logic [31:0] q_s, r_s;
  logic [31:0] q_u, r_u;

  assign prod_s = $signed({{32{src_a[31]}}, src_a}) * $signed({{32{src_b[31]}}, src_b});
  assign prod_u = {32'd0, src_a} * {32'd0, src_b};

  // A zero divisor is replaced by 1 so the dividers never see it; the result is discarded anyway.
  assign div_zero = (src_b == 32'd0);
  assign divisor  = div_zero ? 32'd1 : src_b;

  // Signed divide works on magnitudes; 0x80000000 keeps its bit pattern and yields the wrapped quotient.
  assign mag_a = src_a[31]   ? (32'd0 - src_a)   : src_a;
  assign mag_b = divisor[31] ? (32'd0 - divisor) : divisor;
  assign q_mag = mag_a / mag_b;
  assign r_mag = mag_a % mag_b;
  assign q_s   = (src_a[31] ^ divisor[31]) ? (32'd0 - q_mag) : q_mag;
  assign r_s   = src_a[31] ? (32'd0 - r_mag) : r_mag;

  assign q_u = src_a / divisor;
  assign r_u = src_a % divisor;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (op)
            OP_MULT: begin
              phi_d   = prod_s[63:32];
              plo_d   = prod_s[31:0];
              cnt_d   = MULT_LOAD;
              state_d = ST_RUN;
            end
            OP_MULTU: begin
              phi_d   = prod_u[63:32];
              plo_d   = prod_u[31:0];
              cnt_d   = MULT_LOAD;
              state_d = ST_RUN;
            end
            OP_DIV: begin
              phi_d   = div_zero ? hi_q : r_s;
              plo_d   = div_zero ? lo_q : q_s;
              cnt_d   = DIV_LOAD;
              state_d = ST_RUN;
            end
            OP_DIVU: begin
              phi_d   = div_zero ? hi_q : r_u;
              plo_d   = div_zero ? lo_q : q_u;
              cnt_d   = DIV_LOAD;
              state_d = ST_RUN;
            end
            OP_MTHI: hi_d = src_a;
            OP_MTLO: lo_d = src_a;
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q - 4'd1;
        // Terminal count; <= also recovers from a counter that is somehow already zero.
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          hi_d    = phi_q;
          lo_d    = plo_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      phi_q   <= 32'd0;
      plo_q   <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: directed scenarios followed by random operations,
// checked against an arithmetic reference model of HI/LO.
module tb_md_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  logic [31:0] exp_hi;
  logic [31:0] exp_lo;
  int          checks;
  int          errors;

  md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .src_a (src_a),
    .src_b (src_b),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Reference: returns {hi, lo} after the operation, using 64-bit integer arithmetic.
  function automatic logic [63:0] ref_op(input logic [2:0] o, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] h,
                                         input logic [31:0] l);
    longint          sa, sb, q, r, p;
    longint unsigned ua, ub, uq, ur, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (o)
      3'd0: begin p = sa * sb; return p; end
      3'd1: begin up = ua * ub; return up; end
      3'd2: begin
        if (b == 32'd0) return {h, l};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      3'd3: begin
        if (b == 32'd0) return {h, l};
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
      3'd4: return {a, l};
      3'd5: return {h, a};
      default: return {h, l};
    endcase
  endfunction

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Caller is parked at a negedge; the op is sampled on the next posedge.
  // poke_cycle > 0 pulses an mthi request during that cycle of the busy window.
  task automatic run_md(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int poke_cycle);
    logic [63:0] r;
    int          n;
    r = ref_op(o, a, b, exp_hi, exp_lo);
    n = (o < 3'd2) ? MC : DC;
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(posedge clk); #1;
    start = 1'b0; op = 3'($urandom); src_a = $urandom; src_b = $urandom;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      check32("busy_run", {31'd0, busy}, 32'd1);
      check32("hi_hold", hi, exp_hi);
      check32("lo_hold", lo, exp_lo);
      if (i == poke_cycle) begin
        start = 1'b1; op = 3'd4; src_a = 32'hDEAD; src_b = $urandom;
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
    @(negedge clk);
    exp_hi = r[63:32];
    exp_lo = r[31:0];
    check32("busy_done", {31'd0, busy}, 32'd0);
    check32("hi_result", hi, exp_hi);
    check32("lo_result", lo, exp_lo);
  endtask

  task automatic run_mv(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    r = ref_op(o, a, b, exp_hi, exp_lo);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    exp_hi = r[63:32];
    exp_lo = r[31:0];
    check32("busy_move", {31'd0, busy}, 32'd0);
    check32("hi_move", hi, exp_hi);
    check32("lo_move", lo, exp_lo);
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    checks = 0;
    errors = 0;
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    reset = 1'b0;
    start = 1'b1;
    op = 3'd4;
    src_a = 32'hFFFF_0000;
    src_b = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check32("reset_busy", {31'd0, busy}, 32'd0);
    check32("reset_hi", hi, 32'd0);
    check32("reset_lo", lo, 32'd0);
    start = 1'b0;
    reset = 1'b1;

    run_md(3'd0, 32'hFFFF_FFFD, 32'd5, 0);
    check32("mult_neg_hi", hi, 32'hFFFF_FFFF);
    check32("mult_neg_lo", lo, 32'hFFFF_FFF1);

    run_md(3'd1, 32'hFFFF_FFFF, 32'd2, 0);
    check32("multu_hi", hi, 32'd1);
    check32("multu_lo", lo, 32'hFFFF_FFFE);
    run_md(3'd2, 32'hFFFF_FFF9, 32'd2, 0);
    check32("div_neg_hi", hi, 32'hFFFF_FFFF);
    check32("div_neg_lo", lo, 32'hFFFF_FFFD);

    run_mv(3'd4, 32'd1, 32'd0);
    run_mv(3'd5, 32'd2, 32'd0);
    run_md(3'd3, 32'd7, 32'd0, 0);
    check32("divz_hi", hi, 32'd1);
    check32("divz_lo", lo, 32'd2);
    run_md(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    check32("div_ovf_hi", hi, 32'd0);
    check32("div_ovf_lo", lo, 32'h8000_0000);

    run_mv(3'd4, 32'h1234_5678, 32'd0);
    check32("mthi_hi", hi, 32'h1234_5678);
    run_mv(3'd5, 32'hA5A5_A5A5, 32'd0);
    check32("mtlo_lo", lo, 32'hA5A5_A5A5);

    run_md(3'd0, 32'd3, 32'd4, 2);
    check32("poke_hi", hi, 32'd0);
    check32("poke_lo", lo, 32'd12);

    start = 1'b1; op = 3'd3; src_a = 32'd100; src_b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check32("busy_pre_rst", {31'd0, busy}, 32'd1);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    check32("rst_busy", {31'd0, busy}, 32'd0);
    check32("rst_hi", hi, 32'd0);
    check32("rst_lo", lo, 32'd0);
    repeat (DC) begin
      @(negedge clk);
      check32("rst_no_wb_busy", {31'd0, busy}, 32'd0);
      check32("rst_no_wb_lo", lo, 32'd0);
    end
    run_md(3'd0, 32'd2, 32'd2, 0);
    check32("post_rst_lo", lo, 32'd4);

    for (int k = 0; k < 60; k++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: begin ra = 32'($urandom_range(0, 50)) - 32'd25; rb = 32'($urandom_range(0, 10)) - 32'd5; end
        default: ;
      endcase
      if (ro < 3'd4) run_md(ro, ra, rb, $urandom_range(0, 12));
      else run_mv(ro, ra, rb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
